// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// Control path of a 5-stage ARM-subset pipeline. Decodes the D-stage
// instruction fields, carries the control bits through the D->E, E->M and
// M->W registers, evaluates the condition code in E against the NZCV flag
// register and gates the write enables with the result.
//
// Parameters
//   ALUCTRL_W  ALUControl width (2 or 3); 3 adds the EOR operation (code 100)
//   FLAGS_RST  reset value of the NZCV flag register
//
// Optional feature
//   CTRL_SQUASH_CNT_EN  when defined, SquashCnt counts instructions squashed
//                       in E (saturating); when undefined it is tied to 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   Cond/Op/Funct/Rd  D-stage instruction fields
//   ALUFlags          NZCV from the ALU in E
//   FlushE            turns the next E-register load into a bubble
//   RegSrcD, ImmSrcD  combinational D-stage decode
//   ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE     E-stage controls
//   RegWriteM, MemWriteM                              M-stage controls
//   RegWriteW, MemtoRegW, PCSrcW                      W-stage controls
//   FlagsQ            NZCV register; SquashCnt  squashed-instruction count
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int         ALUCTRL_W = 2,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 BranchTakenE,
  output logic                 MemtoRegE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic [3:0]           FlagsQ,
  output logic [15:0]          SquashCnt
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4
  } alu_op_e;

  // ---------------------------------------------------------------- decode
  logic       alu_src_d, reg_w_d, mem_w_d, mem_to_reg_d, branch_d, pcs_d;
  logic [1:0] flag_w_d;
  alu_op_e    alu_op_d;
  logic       s_bit;

  assign s_bit = Funct[0];

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    RegSrcD      = 2'b00;
    ImmSrcD      = 2'b00;
    alu_src_d    = 1'b0;
    alu_op_d     = ALU_ADD;
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    mem_to_reg_d = 1'b0;
    flag_w_d     = 2'b00;
    branch_d     = 1'b0;
    unique case (Op)
      2'b00: begin
        alu_src_d = Funct[5];
        unique case (Funct[4:1])
          4'b0100: begin alu_op_d = ALU_ADD; reg_w_d = 1'b1; flag_w_d = {2{s_bit}}; end
          4'b0010: begin alu_op_d = ALU_SUB; reg_w_d = 1'b1; flag_w_d = {2{s_bit}}; end
          4'b0000: begin alu_op_d = ALU_AND; reg_w_d = 1'b1; flag_w_d = {s_bit, 1'b0}; end
          4'b1100: begin alu_op_d = ALU_ORR; reg_w_d = 1'b1; flag_w_d = {s_bit, 1'b0}; end
          4'b1010: begin alu_op_d = ALU_SUB; flag_w_d = 2'b11; end  // CMP: flags only
          4'b0001: begin
            // EOR exists only when ALUControl is wide enough to encode it.
            if (ALUCTRL_W >= 3) begin
              alu_op_d = ALU_EOR;
              reg_w_d  = 1'b1;
              flag_w_d = {s_bit, 1'b0};
            end
          end
          default: ;
        endcase
      end
      2'b01: begin
        alu_src_d = 1'b1;
        ImmSrcD   = 2'b01;
        alu_op_d  = Funct[3] ? ALU_ADD : ALU_SUB;  // U bit picks offset sign
        if (Funct[0]) begin
          reg_w_d      = 1'b1;
          mem_to_reg_d = 1'b1;
        end else begin
          mem_w_d = 1'b1;
          RegSrcD = 2'b10;  // STR reads Rd as the store data register
        end
      end
      2'b10: begin
        branch_d  = 1'b1;
        alu_src_d = 1'b1;
        ImmSrcD   = 2'b10;
        RegSrcD   = 2'b01;  // branch base is the PC
      end
      default: ;  // Op=11: no-op
    endcase
  end

  assign pcs_d = reg_w_d & (Rd == 4'hF);

  // ------------------------------------------------------------- E stage
  logic [3:0]           cond_e;
  logic                 reg_w_e, mem_w_e, pcs_e, branch_e;
  logic [1:0]           flag_w_e;
  logic [ALUCTRL_W-1:0] alu_op_trunc;
  logic [3:0]           flags_q;
  logic                 cond_ex_e;

  assign alu_op_trunc = alu_op_d[ALUCTRL_W-1:0];

  // NOTE: pipeline state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of block order.
  // NOTE: the asynchronous reset turns every stage into a bubble, dropping
  // whatever instruction was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE) begin
      if (!rst_n) begin
        cond_e      <= 4'b0000;
        reg_w_e     <= 1'b0;
        mem_w_e     <= 1'b0;
        MemtoRegE   <= 1'b0;
        ALUSrcE     <= 1'b0;
        ALUControlE <= '0;
        flag_w_e    <= 2'b00;
        branch_e    <= 1'b0;
        pcs_e       <= 1'b0;
      end else begin
        cond_e      <= 4'b0000;
        reg_w_e     <= 1'b0;
        mem_w_e     <= 1'b0;
        MemtoRegE   <= 1'b0;
        ALUSrcE     <= 1'b0;
        ALUControlE <= '0;
        flag_w_e    <= 2'b00;
        branch_e    <= 1'b0;
        pcs_e       <= 1'b0;
      end
    end else begin
      cond_e      <= Cond;
      reg_w_e     <= reg_w_d;
      mem_w_e     <= mem_w_d;
      MemtoRegE   <= mem_to_reg_d;
      ALUSrcE     <= alu_src_d;
      ALUControlE <= alu_op_trunc;
      flag_w_e    <= flag_w_d;
      branch_e    <= branch_d;
      pcs_e       <= pcs_d;
    end
  end

  // Condition check against the architectural flags (no bypass from ALU).
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    unique case (cond_e)
      4'b0000: cond_ex_e = fz;
      4'b0001: cond_ex_e = ~fz;
      4'b0010: cond_ex_e = fc;
      4'b0011: cond_ex_e = ~fc;
      4'b0100: cond_ex_e = fn;
      4'b0101: cond_ex_e = ~fn;
      4'b0110: cond_ex_e = fv;
      4'b0111: cond_ex_e = ~fv;
      4'b1000: cond_ex_e = fc & ~fz;
      4'b1001: cond_ex_e = ~fc | fz;
      4'b1010: cond_ex_e = (fn == fv);
      4'b1011: cond_ex_e = (fn != fv);
      4'b1100: cond_ex_e = ~fz & (fn == fv);
      4'b1101: cond_ex_e = fz | (fn != fv);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;  // 1111 never executes
    endcase
  end

  assign BranchTakenE = branch_e & cond_ex_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
    end else if (cond_ex_e) begin
      if (flag_w_e[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w_e[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign FlagsQ = flags_q;

  // -------------------------------------------------------- M and W stages
  logic mem_to_reg_m, pcs_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pcs_m        <= 1'b0;
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      PCSrcW       <= 1'b0;
    end else begin
      RegWriteM    <= reg_w_e & cond_ex_e;
      MemWriteM    <= mem_w_e & cond_ex_e;
      mem_to_reg_m <= MemtoRegE;
      pcs_m        <= pcs_e & cond_ex_e;
      RegWriteW    <= RegWriteM;
      MemtoRegW    <= mem_to_reg_m;
      PCSrcW       <= pcs_m;
    end
  end

  // ------------------------------------------------------ squash counter
`ifdef CTRL_SQUASH_CNT_EN
  logic        valid_e;  // distinguishes real instructions from bubbles
  logic [15:0] squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e    <= 1'b0;
      squash_cnt <= 16'd0;
    end else begin
      valid_e <= ~FlushE;
      if (valid_e && !cond_ex_e && squash_cnt != 16'hFFFF)
        squash_cnt <= squash_cnt + 16'd1;
    end
  end

  assign SquashCnt = squash_cnt;
`else
  assign SquashCnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_control_unit
//
// Directed-vector bench for pipelined_control_unit. Two instances share the
// stimulus: the default build (ALUCTRL_W=2) and one with ALUCTRL_W=3 for EOR.
// Expected values are hand-derived from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [3:0]  ALUFlags;
  logic        FlushE;

  logic [1:0]  reg_src_d, imm_src_d, reg_src_d3, imm_src_d3;
  logic        alu_src_e, br_taken_e, mem_to_reg_e, reg_write_m, mem_write_m;
  logic        reg_write_w, mem_to_reg_w, pc_src_w;
  logic [1:0]  alu_ctrl_e;
  logic [3:0]  flags_q;
  logic [15:0] squash_cnt;

  logic        alu_src_e3, br_taken_e3, mem_to_reg_e3, reg_write_m3, mem_write_m3;
  logic        reg_write_w3, mem_to_reg_w3, pc_src_w3;
  logic [2:0]  alu_ctrl_e3;
  logic [3:0]  flags_q3;
  logic [15:0] squash_cnt3;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sq   = 0;

`ifdef CTRL_SQUASH_CNT_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(reg_src_d), .ImmSrcD(imm_src_d), .ALUSrcE(alu_src_e),
    .ALUControlE(alu_ctrl_e), .BranchTakenE(br_taken_e), .MemtoRegE(mem_to_reg_e),
    .RegWriteM(reg_write_m), .MemWriteM(mem_write_m), .RegWriteW(reg_write_w),
    .MemtoRegW(mem_to_reg_w), .PCSrcW(pc_src_w), .FlagsQ(flags_q),
    .SquashCnt(squash_cnt)
  );

  pipelined_control_unit #(.ALUCTRL_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(reg_src_d3), .ImmSrcD(imm_src_d3), .ALUSrcE(alu_src_e3),
    .ALUControlE(alu_ctrl_e3), .BranchTakenE(br_taken_e3), .MemtoRegE(mem_to_reg_e3),
    .RegWriteM(reg_write_m3), .MemWriteM(mem_write_m3), .RegWriteW(reg_write_w3),
    .MemtoRegW(mem_to_reg_w3), .PCSrcW(pc_src_w3), .FlagsQ(flags_q3),
    .SquashCnt(squash_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
  endtask

  task automatic nop();
    drive(4'b1110, 2'b11, 6'b000000, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; FlushE = 1'b0; ALUFlags = 4'b0000;
    nop();
    #2;
    // Reset state
    check("rst_regwrite_w", reg_write_w, 0);
    check("rst_memwrite_m", mem_write_m, 0);
    check("rst_branch_taken", br_taken_e, 0);
    check("rst_flags", flags_q, 4'b0000);
    check("rst_squash", squash_cnt, 0);
    step();
    rst_n = 1'b1;

    // ADDS r1: flags 0100 after E edge, RegWriteW 3 cycles after decode
    drive(4'b1110, 2'b00, 6'b001001, 4'd1);
    #1;
    check("adds_regsrc_d", reg_src_d, 2'b00);
    check("adds_immsrc_d", imm_src_d, 2'b00);
    step();
    check("adds_aluctrl_e", alu_ctrl_e, 2'b00);
    check("adds_alusrc_e", alu_src_e, 0);
    ALUFlags = 4'b0100;
    nop();
    step();
    check("adds_flags", flags_q, 4'b0100);
    check("adds_regwrite_m", reg_write_m, 1);
    check("adds_regwrite_w_early", reg_write_w, 0);
    step();
    check("adds_regwrite_w", reg_write_w, 1);

    // CMP with ALUFlags=0000 then BEQ: not taken, squashed
    drive(4'b1110, 2'b00, 6'b010101, 4'd0);
    step();
    ALUFlags = 4'b0000;
    drive(4'b0000, 2'b10, 6'b000000, 4'd0);
    #1;
    check("beq_regsrc_d", reg_src_d, 2'b01);
    check("beq_immsrc_d", imm_src_d, 2'b10);
    step();
    check("cmp0_flags", flags_q, 4'b0000);
    check("cmp0_regwrite_m", reg_write_m, 0);
    check("beq_not_taken", br_taken_e, 0);
    nop();
    step();
    if (SQ_EN) exp_sq++;
    check("beq_squash", squash_cnt, exp_sq);

    // CMP with ALUFlags=0100 then BEQ: taken
    drive(4'b1110, 2'b00, 6'b010101, 4'd0);
    step();
    ALUFlags = 4'b0100;
    drive(4'b0000, 2'b10, 6'b000000, 4'd0);
    step();
    check("cmp1_flags", flags_q, 4'b0100);
    check("beq_taken", br_taken_e, 1);
    nop();
    step();
    check("beq_taken_squash", squash_cnt, exp_sq);

    // LDR r15
    drive(4'b1110, 2'b01, 6'b011001, 4'd15);
    #1;
    check("ldr_regsrc_d", reg_src_d, 2'b00);
    check("ldr_immsrc_d", imm_src_d, 2'b01);
    step();
    check("ldr_alusrc_e", alu_src_e, 1);
    check("ldr_aluctrl_e", alu_ctrl_e, 2'b00);
    check("ldr_memtoreg_e", mem_to_reg_e, 1);
    nop();
    step();
    check("ldr_regwrite_m", reg_write_m, 1);
    step();
    check("ldr_pcsrc_w", pc_src_w, 1);
    check("ldr_memtoreg_w", mem_to_reg_w, 1);
    check("ldr_regwrite_w", reg_write_w, 1);

    // STR with U=0 (subtract offset)
    drive(4'b1110, 2'b01, 6'b010000, 4'd2);
    #1;
    check("str_regsrc_d", reg_src_d, 2'b10);
    step();
    check("str_aluctrl_e", alu_ctrl_e, 2'b01);
    nop();
    step();
    check("str_memwrite_m", mem_write_m, 1);
    check("str_regwrite_m", reg_write_m, 0);

    // FlushE with STR in D: bubble reaches M
    drive(4'b1110, 2'b01, 6'b010000, 4'd2);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    nop();
    step();
    check("flush_str_memwrite_m", mem_write_m, 0);

    // FlushE while ADDS is in E: ADDS still updates flags and completes
    drive(4'b1110, 2'b00, 6'b001001, 4'd1);
    step();
    FlushE = 1'b1;
    ALUFlags = 4'b1000;
    nop();
    step();
    FlushE = 1'b0;
    check("flushadds_flags", flags_q, 4'b1000);
    check("flushadds_regwrite_m", reg_write_m, 1);
    step();
    check("flush_bubble_regwrite_m", reg_write_m, 0);
    check("bubble_no_squash", squash_cnt, exp_sq);

    // Cond=1111 never executes
    drive(4'b1111, 2'b00, 6'b001000, 4'd4);
    step();
    nop();
    step();
    check("nv_regwrite_m", reg_write_m, 0);
    if (SQ_EN) exp_sq++;
    check("nv_squash", squash_cnt, exp_sq);

    // EORS: supported only in the 3-bit build
    drive(4'b1110, 2'b00, 6'b000011, 4'd5);
    step();
    check("eors_aluctrl_e3", alu_ctrl_e3, 3'b100);
    check("eor_aluctrl_e2", alu_ctrl_e, 2'b00);
    ALUFlags = 4'b0111;
    nop();
    step();
    check("eors_flags3", flags_q3, 4'b0100);
    check("eor_flags2", flags_q, 4'b1000);
    check("eors_regwrite_m3", reg_write_m3, 1);
    check("eor_regwrite_m2", reg_write_m, 0);

    // Reset mid-stream, between clock edges
    drive(4'b1110, 2'b01, 6'b011001, 4'd15);
    step();
    nop();
    step();
    check("pre_rst_regwrite_m", reg_write_m, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_regwrite_m", reg_write_m, 0);
    check("async_rst_memwrite_m", mem_write_m, 0);
    check("async_rst_regwrite_w", reg_write_w, 0);
    check("async_rst_pcsrc_w", pc_src_w, 0);
    check("async_rst_flags", flags_q, 4'b0000);
    check("async_rst_flags3", flags_q3, 4'b0000);
    check("async_rst_squash", squash_cnt, 0);
    drive(4'b1110, 2'b00, 6'b001000, 4'd3);
    #2;
    rst_n = 1'b1;
    step();
    nop();
    step();
    check("post_rst_regwrite_w_early", reg_write_w, 0);
    step();
    check("post_rst_regwrite_w", reg_write_w, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 2: ALUControl width; 3 enables the EOR operation.
REQ-002 Parameter FLAGS_RST, default 4'b0000: reset value of NZCV flag register.
REQ-003 clk  in  1  rising-edge clock; one clock domain.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Cond  in  4  Cond field of the D-stage instruction.
REQ-006 Op  in  2  Op field of the D-stage instruction.
REQ-007 Funct  in  6  Funct field of the D-stage instruction.
REQ-008 Rd  in  4  Rd field of the D-stage instruction.
REQ-009 ALUFlags  in  4  NZCV from ALU, E stage.
REQ-010 FlushE  in  1  from hazard unit; loads a bubble into the E register.
REQ-011 RegSrcD, ImmSrcD  out  2 each  combinational D-stage decode.
REQ-012 ALUSrcE  out  1; ALUControlE  out  ALUCTRL_W.
REQ-013 BranchTakenE  out  1  taken branch in E.
REQ-014 MemtoRegE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, PCSrcW  out  1 each.
REQ-015 FlagsQ  out  4  NZCV register. SquashCnt  out  16  (see Configuration).

Function
REQ-016 Op=00 decode (data processing):
- ALUSrc=Funct[5], ImmSrc=00, RegSrc=00.
- Funct[4:1] mapping to ALUControl: ADD 0100->0, SUB 0010->1, AND 0000->2, ORR 1100->3, CMP 1010->1 with RegW=0.
- EOR 0001->4 only when ALUCTRL_W=3.
- Any other cmd: RegW=0, FlagW=00.
REQ-017 FlagW for data processing: FlagW=11 for ADD/SUB when S=Funct[0] is set, and always for CMP. FlagW=10 for AND/ORR/EOR when S is set. FlagW=00 otherwise.
REQ-018 Op=01 decode (memory):
- ALUSrc=1, ImmSrc=01, ALUControl=ADD if Funct[3] else SUB.
- Funct[0]=1 (LDR): RegW=1, MemtoReg=1, RegSrc=00.
- Funct[0]=0 (STR): MemW=1, RegSrc=10.
REQ-019 Op=10 decode (branch): Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=ADD. Op=11 decodes as a no-op with all write enables 0.
REQ-020 PCS=1 iff RegW=1 and Rd=4'hF.
REQ-021 D->E register: every clk edge it captures Cond, RegW, MemW, MemtoReg, ALUSrc, ALUControl, FlagW, Branch and PCS. FlushE=1 loads all enables and FlagW as 0.
REQ-022 CondExE evaluates Cond against FlagsQ per the ARM table EQ..AL. Cond 1111 evaluates false.
REQ-023 Gated enables:
- BranchTakenE = BranchE & CondExE.
- E->M register captures RegW&CondExE, MemW&CondExE, MemtoReg, PCS&CondExE.
- M->W register forwards RegWrite, MemtoReg, PCSrc.
- Net latency from decode to W outputs is 3 cycles.
REQ-024 Flag register update on clk edge when CondExE: FlagWE[1] loads N,Z from ALUFlags[3:2]; FlagWE[0] loads C,V from ALUFlags[1:0]. Otherwise FlagsQ holds.
REQ-025 Back-to-back flag setter followed by a conditional instruction: the second instruction uses the updated FlagsQ; no bypass is required.
REQ-026 FlushE in the same cycle as a flag-setting E instruction: that E instruction still updates flags. The bubble enters E next cycle.

Reset
REQ-027 rst_n low clears all pipeline registers (bubbles) and sets FlagsQ=FLAGS_RST and SquashCnt=0, immediately and independent of clk.
REQ-028 An in-flight instruction is discarded on reset mid-operation. The first valid W output appears 3 cycles after rst_n rises.

Configuration
REQ-029 Macro CTRL_SQUASH_CNT_EN defined: SquashCnt increments on each clk edge where E holds a non-bubble instruction and CondExE=0. The count saturates at 16'hFFFF.
REQ-030 Macro CTRL_SQUASH_CNT_EN undefined: SquashCnt is constant 0 and no counter flops exist.

Verification
REQ-031 ADDS (Op=00, Funct=001001), ALUFlags=0100 -> RegWriteW=1 3 cycles later; FlagsQ=0100 after E edge.
REQ-032 CMP, ALUFlags=0100, then BEQ -> BranchTakenE=1 in the BEQ's E cycle. With ALUFlags=0000 instead -> BranchTakenE=0 and SquashCnt+1 when enabled.
REQ-033 LDR with Rd=15 -> PCSrcW=1, MemtoRegW=1. STR -> MemWriteM=1, RegWriteM=0, RegSrcD=10.
REQ-034 FlushE=1 with a STR in D -> MemWriteM=0 two cycles later.
REQ-035 rst_n pulsed low mid-stream -> all write outputs 0 and FlagsQ=FLAGS_RST without a clk edge.
REQ-036 ALUCTRL_W=3, EORS -> ALUControlE=100, FlagW=10. ALUCTRL_W=2, EOR -> RegWriteM=0.
